// File: rtl/disarm_sequencer.sv
// Disarm sequencer: throttle gate, then per-channel req/ack disarm
// with timeout, packed status word and one-cycle done pulse.
//
// Ports:
//   clk_i       system clock
//   rst_i       synchronous active-high reset
//   start_i     disarm request, accepted only in IDLE
//   force_i     sampled with start; skips throttle gate, rides timeouts
//   throttle_i  throttle command, unsigned
//   ch_ack_i    per-channel disarm acknowledge
//   ch_req_o    per-channel disarm request, one-hot or zero
//   busy_o      high outside IDLE
//   done_o      one-cycle completion pulse
//   result_o    {mask[15:0], fail_idx[7:0], 4'h0, status[3:0]}
module disarm_sequencer #(
  parameter int               NUM_CH         = 4,
  parameter int               THR_W          = 16,
  parameter logic [THR_W-1:0] THR_MAX        = THR_W'(200),
  parameter int               TIMEOUT_CYCLES = 1000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              force_i,
  input  logic [THR_W-1:0]  throttle_i,
  input  logic [NUM_CH-1:0] ch_ack_i,
  output logic [NUM_CH-1:0] ch_req_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [31:0]       result_o
);

  localparam int IW =
    (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    WAIT,
    DONE
  } state_t;

  state_t            state_q;
  logic [NUM_CH-1:0] ch_req_q;
  logic              busy_q;
  logic              done_q;
  logic [31:0]       result_q;
  logic [TW-1:0]     timer_q;
  logic [IW-1:0]     idx_q;
  logic              force_q;
  logic [NUM_CH-1:0] mask_q;
  logic [7:0]        fail_q;

  logic              ack_hit;
  logic              tmo;
  logic              last;
  logic [NUM_CH-1:0] mask_d;
  logic [7:0]        fail_d;

  // ch_req_q is one-hot on idx while waiting, so it
  // selects the live ack bit and the mask bit directly.
  assign ack_hit = |(ch_ack_i & ch_req_q);
  assign tmo     = timer_q == TW'(TIMEOUT_CYCLES - 1);
  assign last    = ch_req_q[NUM_CH-1];
  assign mask_d  = ack_hit ? (mask_q | ch_req_q) : mask_q;
  // 8'hFF marks "no failure yet"; only the first timeout sticks.
  assign fail_d  = (tmo && !ack_hit && fail_q == 8'hFF)
                 ? 8'(idx_q) : fail_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      ch_req_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      timer_q  <= '0;
      idx_q    <= '0;
      force_q  <= 1'b0;
      mask_q   <= '0;
      fail_q   <= 8'hFF;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            force_q <= force_i;
            mask_q  <= '0;
            fail_q  <= 8'hFF;
            timer_q <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (throttle_i > THR_MAX && !force_q) begin
            result_q <= {16'h0, 8'hFF, 4'h0, 4'd1};
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            ch_req_q <= NUM_CH'(1);
            timer_q  <= '0;
            idx_q    <= '0;
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          mask_q <= mask_d;
          fail_q <= fail_d;
          if (tmo && !ack_hit && !force_q) begin
            result_q <= {16'(mask_d), fail_d, 4'h0, 4'd2};
            ch_req_q <= '0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else if (ack_hit || tmo) begin
            if (last) begin
              result_q <= {16'(mask_d), fail_d, 4'h0,
                           (fail_d == 8'hFF) ? 4'd0 : 4'd3};
              ch_req_q <= '0;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else begin
              ch_req_q <= ch_req_q << 1;
              idx_q    <= idx_q + IW'(1);
              timer_q  <= '0;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ch_req_o = ch_req_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: doc/disarm_sequencer.md
Name: disarm_sequencer

Overview:
Parametrised successor of the single-shot disarm block. On `start`, it checks throttle, then disarms NUM_CH actuator channels in order (channel 0 first), using a req/ack handshake per channel with a per-channel timeout. It reports a packed 32-bit status word and pulses `done`. It sits between the flight-mode FSM and the per-motor ESC/actuator interfaces.

Parameters:
NUM_CH, 4, number of actuator channels (legal range 1..16)
THR_W, 16, throttle input width
THR_MAX, 16'd200, highest throttle value allowed for a non-forced disarm
TIMEOUT_CYCLES, 1000, cycles a channel may wait for ack (must be >= 1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  disarm request; accepted only in IDLE
force  in  1  sampled with an accepted start; bypasses the throttle check and continues past timeouts
throttle  in  THR_W  current throttle command, unsigned
ch_ack  in  NUM_CH  per-channel disarm acknowledge
ch_req  out  NUM_CH  per-channel disarm request, one-hot or zero
busy  out  1  high in every state except IDLE
done  out  1  high for exactly one cycle, in DONE
result  out  32  status word; valid while done=1 and held until the next accepted start

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high. All outputs are registered.
- Reset values: state=IDLE, ch_req=0, busy=0, done=0, result=0, internal timer=0, channel index=0, force_q=0.
- States and transitions:
  - IDLE: on start=1, latch force into force_q, clear the working result, go to CHECK. While busy, start is ignored.
  - CHECK, 1 cycle, tests throttle:
    - throttle > THR_MAX and force_q=0: go to DONE with status 1.
    - otherwise: go to WAIT with idx=0, ch_req = 1<<0, timer=0.
  - WAIT: ch_req[idx]=1; timer increments each cycle. Precedence for a channel:
    - ch_ack[idx]=1: set mask bit idx. Then go to WAIT for idx+1 (ch_req moves one-hot, timer=0), or to DONE if idx=NUM_CH-1.
    - otherwise timer == TIMEOUT_CYCLES-1: timeout. If fail_idx is unset, record fail_idx=idx.
      - force_q=1: advance exactly as for an ack, but leave the mask bit clear.
      - force_q=0: go to DONE with status 2.
    - ack wins over timeout when both occur in the same cycle.
  - DONE: ch_req=0, done=1, result updated; next state is IDLE.
- Timing and waiting:
  - ch_ack bits for channels other than idx are ignored.
  - An ack already high on entry to WAIT is accepted in the first WAIT cycle.
  - Each channel waits at most TIMEOUT_CYCLES cycles.
- Result encoding:
  - [3:0] status: 0 = all channels disarmed, 1 = throttle high, 2 = timeout abort, 3 = forced with at least one timeout.
  - [7:4] reserved, 0.
  - [15:8] index of the first failing channel, 8'hFF if none.
  - [31:16] disarmed-channel mask, bit i = channel i acked; bits at and above NUM_CH read 0.
- Latency: start accepted at cycle T, all acks immediate, gives done at T+2+NUM_CH (T+6 for NUM_CH=4).
- Throttle comparison is unsigned, and `throttle == THR_MAX` passes the check.
- rst asserted in any state gives reset values on the next edge: ch_req drops immediately, no done pulse, and the previous result is cleared.
- start asserted in the DONE cycle is ignored; it is accepted in IDLE on the following cycle if still high.

Test Plan:
- NUM_CH=4, throttle=100, ch_ack=4'hF held, start at T -> ch_req 0001, 0010, 0100, 1000 on T+2..T+5; done=1 at T+6; result=32'h000F_FF00.
- throttle=201, force=0, start -> done at T+2; ch_req never asserted; result=32'h0000_FF01. Repeat with throttle=200 -> sequence runs normally.
- TIMEOUT_CYCLES=8, ch2 never acks, force=0 -> ch_req[2] high for exactly 8 cycles; result=32'h0003_0202; ch_req[3] never asserted.
- Same as above with force=1 -> channel 3 still requested; result=32'h000B_0203.
- ch_ack[2] rises in the same cycle as ch2's timeout -> counted as ack; status 0, mask 4'hF.
- rst asserted while in WAIT on ch1 -> next cycle ch_req=0, busy=0, result=0, done stays 0. A new start afterwards runs a full sequence from channel 0.
